// File: rtl/demo_de0_sys_data_format_adapter_packer.sv
// Channelised symbol packer: 1 symbol/beat in, 2 symbols/beat out.
// Per-channel state lives in an external 2-bit state RAM with 2-cycle reads.
module demo_de0_sys_data_format_adapter_packer #(
  parameter int SYMBOL_WIDTH  = 8,
  parameter int CHANNEL_WIDTH = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SYMBOL_WIDTH-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNEL_WIDTH-1:0]  in_channel,
  input  logic                      in_startofpacket,
  input  logic                      in_endofpacket,
  output logic [2*SYMBOL_WIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNEL_WIDTH-1:0]  out_channel,
  output logic                      out_startofpacket,
  output logic                      out_endofpacket,
  output logic                      out_empty,
  output logic [CHANNEL_WIDTH-1:0]  state_wr_address,
  output logic [1:0]                state_wr_writedata,
  output logic                      state_wr_write,
  input  logic                      state_wr_waitrequest,
  output logic [CHANNEL_WIDTH-1:0]  state_rd_address,
  input  logic [1:0]                state_rd_readdata
);

  localparam int SW  = SYMBOL_WIDTH;
  localparam int CW  = CHANNEL_WIDTH;
  localparam int NCH = 1 << CW;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int KW  = $clog2(FIFO_DEPTH + 3);

  typedef struct packed {
    logic [SW-1:0] data;
    logic [CW-1:0] ch;
    logic          sop;
    logic          eop;
  } beat_in_t;

  typedef struct packed {
    logic [2*SW-1:0] data;
    logic [CW-1:0]   ch;
    logic            sop;
    logic            eop;
    logic            empty;
  } beat_out_t;

  logic          v1_q, v2_q;
  beat_in_t      s1_q, s2_q;
  logic [SW-1:0] hold_q [NCH];
  beat_out_t     fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [KW-1:0] cnt_q, cnt_d;

  logic      accept;
  logic      push;
  logic      pop;
  logic      hold_we;
  logic [1:0] wr_data;
  beat_out_t pbeat;
  beat_out_t head;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit counts every in-flight beat, so a push can never hit a full FIFO
  assign in_ready = !state_wr_waitrequest &&
                    ((cnt_q + KW'(v1_q) + KW'(v2_q)) < KW'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;

  assign state_rd_address   = in_channel;
  assign state_wr_address   = s2_q.ch;
  assign state_wr_writedata = wr_data;
  assign state_wr_write     = v2_q;

  always_comb begin
    push    = 1'b0;
    hold_we = 1'b0;
    wr_data = 2'b00;
    pbeat   = '0;
    pbeat.ch = s2_q.ch;
    if (v2_q) begin
      if (!state_rd_readdata[0]) begin
        if (!s2_q.eop) begin
          hold_we = 1'b1;
          wr_data = {s2_q.sop, 1'b1};
        end else begin
          push        = 1'b1;
          pbeat.data  = {s2_q.data, {SW{1'b0}}};
          pbeat.sop   = s2_q.sop;
          pbeat.eop   = 1'b1;
          pbeat.empty = 1'b1;
        end
      end else begin
        push        = 1'b1;
        pbeat.data  = {hold_q[s2_q.ch], s2_q.data};
        pbeat.sop   = state_rd_readdata[1] | s2_q.sop;
        pbeat.eop   = s2_q.eop;
        pbeat.empty = 1'b0;
      end
    end
  end

  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign head      = fifo_q[rp_q];

  assign out_data          = head.data;
  assign out_channel       = head.ch;
  assign out_startofpacket = head.sop;
  assign out_endofpacket   = head.eop;
  assign out_empty         = head.empty;

  always_comb begin
    wp_d  = push ? nxt(wp_q) : wp_q;
    rp_d  = pop  ? nxt(rp_q) : rp_q;
    cnt_d = cnt_q + KW'(push) - KW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      v1_q <= accept;
      v2_q <= v1_q;
      if (accept) begin
        s1_q.data <= in_data;
        s1_q.ch   <= in_channel;
        s1_q.sop  <= in_startofpacket;
        s1_q.eop  <= in_endofpacket;
      end
      s2_q  <= s1_q;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) hold_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (hold_we) hold_q[s2_q.ch] <= s2_q.data;
      if (push) fifo_q[wp_q] <= pbeat;
    end
  end

endmodule

// File: tb/tb_demo_de0_sys_data_format_adapter_packer.sv
// Bench for the symbol packer: state RAM model, packet-level reference
// model and scoreboard, directed cases then randomized traffic.
module tb_demo_de0_sys_data_format_adapter_packer;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_channel;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_channel;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic        out_empty;
  logic        state_wr_address;
  logic [1:0]  state_wr_writedata;
  logic        state_wr_write;
  logic        state_wr_waitrequest;
  logic        state_rd_address;
  logic [1:0]  state_rd_readdata;

  demo_de0_sys_data_format_adapter_packer dut (
    .clk                  (clk),
    .reset                (reset),
    .in_data              (in_data),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_channel           (in_channel),
    .in_startofpacket     (in_startofpacket),
    .in_endofpacket       (in_endofpacket),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_channel          (out_channel),
    .out_startofpacket    (out_startofpacket),
    .out_endofpacket      (out_endofpacket),
    .out_empty            (out_empty),
    .state_wr_address     (state_wr_address),
    .state_wr_writedata   (state_wr_writedata),
    .state_wr_write       (state_wr_write),
    .state_wr_waitrequest (state_wr_waitrequest),
    .state_rd_address     (state_rd_address),
    .state_rd_readdata    (state_rd_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // State RAM: clears after reset, 2-cycle read, write lookahead
  logic [1:0] mem [2];
  logic [2:0] clr_cnt;
  logic       rd_addr_q;
  logic [1:0] rd_data_q;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0]    <= 2'b00;
      mem[1]    <= 2'b00;
      clr_cnt   <= 3'd3;
      rd_addr_q <= 1'b0;
      rd_data_q <= 2'b00;
    end else begin
      if (clr_cnt != 3'd0) clr_cnt <= clr_cnt - 3'd1;
      if (state_wr_write) mem[state_wr_address] <= state_wr_writedata;
      rd_addr_q <= state_rd_address;
      if (state_wr_write && state_wr_address == rd_addr_q)
        rd_data_q <= state_wr_writedata;
      else
        rd_data_q <= mem[rd_addr_q];
    end
  end

  assign state_wr_waitrequest = (clr_cnt != 3'd0);
  assign state_rd_readdata    = rd_data_q;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [15:0] d, input logic c,
                                     input logic s, input logic e,
                                     input logic em);
    return {d, c, s, e, em};
  endfunction

  // Reference model: per-channel pending symbol, expected output queue
  bit          hv [2];
  logic [7:0]  hd [2];
  bit          hs [2];
  logic [19:0] expq [$];
  logic [19:0] logq [$];
  int          nacc = 0;
  int          nwr  = 0;
  int          cyc  = 0;
  int          acc_cyc = 0;
  int          ov_cyc  = 0;
  bit          ov_s = 1'b0;
  bit          rdy_s = 1'b0;
  bit          rnd = 1'b0;

  task automatic model(input logic c, input logic [7:0] d,
                       input logic s, input logic e);
    if (!hv[c]) begin
      if (!e) begin
        hv[c] = 1'b1;
        hd[c] = d;
        hs[c] = s;
      end else begin
        expq.push_back(mk({d, 8'h00}, c, s, 1'b1, 1'b1));
      end
    end else begin
      expq.push_back(mk({hd[c], d}, c, hs[c] | s, e, 1'b0));
      hv[c] = 1'b0;
    end
  endtask

  task automatic mon();
    logic [19:0] got;
    rdy_s = in_ready;
    ov_s  = out_valid;
    if (reset) begin
      hv[0] = 1'b0;
      hv[1] = 1'b0;
      expq.delete();
      nacc = 0;
      nwr  = 0;
    end else begin
      if (in_valid && in_ready) begin
        model(in_channel, in_data, in_startofpacket, in_endofpacket);
        nacc++;
        acc_cyc = cyc;
      end
      if (state_wr_write) nwr++;
      if (out_valid) ov_cyc = cyc;
      if (out_valid && out_ready) begin
        got = {out_data, out_channel, out_startofpacket,
               out_endofpacket, out_empty};
        if (expq.size() == 0) chk("unexpected_beat", 32'(got), 32'hFFFFFFFF);
        else chk("out_beat", 32'(got), 32'(expq.pop_front()));
        logq.push_back(got);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    cyc++;
    #1;
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic c, input logic [7:0] d,
                      input logic s, input logic e);
    int n = 0;
    in_valid         = 1'b1;
    in_channel       = c;
    in_data          = d;
    in_startofpacket = s;
    in_endofpacket   = e;
    do begin
      step();
      n++;
    end while (!rdy_s && n < 300);
    if (!rdy_s) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rnd       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    do begin
      step();
      n++;
    end while ((expq.size() != 0 || n < 5) && n < 300);
    chk("drain_done", 32'(expq.size()), 32'd0);
    chk("drain_idle", 32'(out_valid), 32'd0);
    chk("wr_per_beat", 32'(nwr), 32'(nacc));
  endtask

  function automatic logic [19:0] logat(input int i);
    return (i < logq.size()) ? logq[i] : 20'hFFFFF;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_after_clear", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int base;
    int b0;
    int n;
    bit inpk [2];
    int rem [2];
    logic c;
    logic s;
    logic e;

    reset            = 1'b1;
    in_valid         = 1'b0;
    in_data          = 8'h00;
    in_channel       = 1'b0;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    out_ready        = 1'b1;
    #1;
    repeat (3) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_write", 32'(state_wr_write), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_during_clear", 32'(in_ready), 32'd0);
    wait_ready();
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Same-channel pair, with latency from acceptance cycle
    base = logq.size();
    send(1'b0, 8'hA1, 1'b1, 1'b0);
    send(1'b0, 8'hB2, 1'b0, 1'b1);
    n = 0;
    do begin
      step();
      n++;
    end while (!ov_s && n < 20);
    chk("lat_seen", 32'(ov_s), 32'd1);
    chk("latency", 32'(ov_cyc - acc_cyc), 32'd3);
    drain();
    chk("t1_beat", 32'(logat(base)), 32'(mk(16'hA1B2, 0, 1, 1, 0)));

    // Interleaved channels
    base = logq.size();
    send(1'b0, 8'h11, 1'b1, 1'b0);
    send(1'b1, 8'h22, 1'b1, 1'b0);
    send(1'b0, 8'h33, 1'b0, 1'b1);
    send(1'b1, 8'h44, 1'b0, 1'b1);
    drain();
    chk("t2_ch0", 32'(logat(base)), 32'(mk(16'h1133, 0, 1, 1, 0)));
    chk("t2_ch1", 32'(logat(base + 1)), 32'(mk(16'h2244, 1, 1, 1, 0)));

    // Odd-length packet leaves a half-empty tail beat
    base = logq.size();
    send(1'b1, 8'h55, 1'b1, 1'b0);
    send(1'b1, 8'h66, 1'b0, 1'b0);
    send(1'b1, 8'h77, 1'b0, 1'b1);
    drain();
    chk("t3_first", 32'(logat(base)), 32'(mk(16'h5566, 1, 1, 0, 0)));
    chk("t3_tail", 32'(logat(base + 1)), 32'(mk(16'h7700, 1, 0, 1, 1)));

    // Backpressure: credit limit stops input after four queued beats
    base = logq.size();
    out_ready = 1'b0;
    b0 = nacc;
    for (int i = 0; i < 8; i++)
      send(1'b0, 8'(8'h80 + i), (i % 2) == 0, (i % 2) == 1);
    repeat (5) step();
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    chk("bp_accepted", 32'(nacc - b0), 32'd8);
    chk("bp_valid", 32'(out_valid), 32'd1);
    in_valid         = 1'b1;
    in_channel       = 1'b0;
    in_data          = 8'h90;
    in_startofpacket = 1'b1;
    in_endofpacket   = 1'b0;
    repeat (5) step();
    chk("bp_held", 32'(nacc - b0), 32'd8);
    out_ready = 1'b1;
    send(1'b0, 8'h90, 1'b1, 1'b0);
    send(1'b0, 8'h91, 1'b0, 1'b1);
    drain();
    chk("bp_first", 32'(logat(base)), 32'(mk(16'h8081, 0, 1, 1, 0)));
    chk("bp_last", 32'(logat(base + 4)), 32'(mk(16'h9091, 0, 1, 1, 0)));

    // Reset mid-packet with queued output
    out_ready = 1'b0;
    send(1'b1, 8'h01, 1'b1, 1'b0);
    send(1'b1, 8'h02, 1'b0, 1'b1);
    send(1'b0, 8'hEE, 1'b1, 1'b0);
    repeat (4) step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_valid_now", 32'(out_valid), 32'd0);
    chk("rst_ready_now", 32'(in_ready), 32'd0);
    repeat (3) step();
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("ready_reclear", 32'(in_ready), 32'd0);
    wait_ready();
    base = logq.size();
    send(1'b0, 8'hC3, 1'b1, 1'b0);
    send(1'b0, 8'hD4, 1'b0, 1'b1);
    drain();
    chk("post_rst_beat", 32'(logat(base)), 32'(mk(16'hC3D4, 0, 1, 1, 0)));

    // Randomized interleaved packets with random backpressure
    rnd = 1'b1;
    inpk[0] = 1'b0;
    inpk[1] = 1'b0;
    rem[0]  = 0;
    rem[1]  = 0;
    for (int k = 0; k < 300; k++) begin
      c = 1'($urandom_range(0, 1));
      if (!inpk[c]) begin
        rem[c] = $urandom_range(1, 5);
        s = 1'b1;
      end else begin
        s = ($urandom_range(0, 15) == 0);
      end
      e = (rem[c] == 1);
      rem[c]--;
      inpk[c] = (rem[c] != 0);
      send(c, 8'($urandom), s, e);
      if ($urandom_range(0, 3) == 0) step();
    end
    for (int ch = 0; ch < 2; ch++) begin
      while (inpk[ch]) begin
        rem[ch]--;
        inpk[ch] = (rem[ch] != 0);
        send(1'(ch), 8'($urandom), 1'b0, rem[ch] == 0);
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
